// File: rtl/ras_pkg.sv
// Shared types and default sizes for the committed return-address stack.
package ras_pkg;

    localparam int unsigned RAS_DEPTH      = 16;
    localparam int unsigned RAS_WIDTH      = 32;
    localparam int unsigned RAS_ADDR_WIDTH = 10;

    // Committed action, encoded as {pop, push}
    typedef enum logic [1:0] {
        RAS_NOP     = 2'b00,
        RAS_PUSH    = 2'b01,
        RAS_POP     = 2'b10,
        RAS_REPLACE = 2'b11
    } ras_action_e;

    // Restore handshake sequencing
    typedef enum logic [1:0] {
        RS_IDLE = 2'b00,
        RS_READ = 2'b01,
        RS_RESP = 2'b10
    } ras_restore_state_e;

endpackage

// File: rtl/ras_bram.sv
// Simple dual-port storage: port A synchronous read, port B write.
// With RESOLVE_COLLIDE set, a same-cycle write to the read slot is forwarded.
module ras_bram #(
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned WIDTH           = 32,
    parameter bit          RESOLVE_COLLIDE = 1'b1,
    localparam int unsigned ADDR           = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             a_en_i,
    input  logic [ADDR-1:0]  a_addr_i,
    output logic [WIDTH-1:0] a_data_o,
    input  logic             b_we_i,
    input  logic [ADDR-1:0]  b_addr_i,
    input  logic [WIDTH-1:0] b_data_i
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] a_data_q;
    logic             collide_c;

    assign collide_c = RESOLVE_COLLIDE && b_we_i && (b_addr_i == a_addr_i);
    assign a_data_o  = a_data_q;

    // Storage array write; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (b_we_i) begin
            mem_q[b_addr_i] <= b_data_i;
        end
    end

    // Read register: loads only when enabled so the response holds afterwards
    always_ff @(posedge clk) begin
        if (rst_i) begin
            a_data_q <= '0;
        end else if (a_en_i) begin
            a_data_q <= collide_c ? b_data_i : mem_q[a_addr_i];
        end
    end

endmodule

// File: rtl/ras_commit_stack.sv
// Committed return-address stack: applies the committed action stream,
// checks it against its own pointer, and serves post-flush restore requests.
module ras_commit_stack
    import ras_pkg::*;
#(
    parameter int unsigned DEPTH      = RAS_DEPTH,
    parameter int unsigned WIDTH      = RAS_WIDTH,
    parameter int unsigned ADDR_WIDTH = RAS_ADDR_WIDTH,
    localparam int unsigned ADDR      = $clog2(DEPTH),
    localparam int unsigned CNT_W     = ADDR + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  commit,
    input  logic                  pop_i,
    input  logic                  push_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      data_i,
    output logic [ADDR_WIDTH-1:0] tos_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  mismatch,
    input  logic                  restore_req,
    output logic                  restore_valid,
    output logic [ADDR_WIDTH-1:0] restore_addr,
    output logic [WIDTH-1:0]      restore_data,
    output logic                  restore_empty,
    input  logic                  restore_ack
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    ras_action_e           action_c;
    logic [ADDR_WIDTH-1:0] tos_q, tos_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  mis_q, mis_d;

    ras_restore_state_e    state_q, state_d;
    logic                  snap_ld_c;
    logic                  rd_en_c;
    logic [ADDR_WIDTH-1:0] snap_tos_q;
    logic                  snap_empty_q;
    logic                  valid_q;
    logic                  wr_en_c;

    assign action_c = ras_action_e'({pop_i, push_i});

    // Next stack pointer/occupancy and status pulses for this cycle's commit
    always_comb begin
        tos_d   = tos_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        mis_d   = 1'b0;
        if (commit) begin
            case (action_c)
                RAS_PUSH: begin
                    tos_d = addr_i;
                    mis_d = (addr_i != (tos_q + ADDR_WIDTH'(1)));
                    if (count_q == CNT_FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                RAS_POP: begin
                    if (count_q == '0) begin
                        unf_d = 1'b1;
                    end else begin
                        tos_d   = addr_i - ADDR_WIDTH'(1);
                        count_d = count_q - CNT_W'(1);
                        mis_d   = (addr_i != tos_q);
                    end
                end
                RAS_REPLACE: begin
                    tos_d = addr_i;
                    mis_d = (addr_i != tos_q);
                    if (count_q == '0) begin
                        count_d = CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Restore sequencing: snapshot in IDLE, read in READ, hold in RESP
    always_comb begin
        state_d   = state_q;
        snap_ld_c = 1'b0;
        rd_en_c   = 1'b0;
        case (state_q)
            RS_IDLE: begin
                if (restore_req) begin
                    snap_ld_c = 1'b1;
                    state_d   = RS_READ;
                end
            end
            RS_READ: begin
                rd_en_c = 1'b1;
                state_d = RS_RESP;
            end
            RS_RESP: begin
                if (restore_ack) begin
                    state_d = RS_IDLE;
                end
            end
            default: begin
                state_d = RS_IDLE;
            end
        endcase
    end

    // Architectural state, pulses, snapshot and FSM registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tos_q        <= '1;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            mis_q        <= 1'b0;
            state_q      <= RS_IDLE;
            snap_tos_q   <= '0;
            snap_empty_q <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            tos_q   <= tos_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            mis_q   <= mis_d;
            state_q <= state_d;
            valid_q <= (state_d == RS_RESP);
            if (snap_ld_c) begin
                snap_tos_q   <= tos_d;
                snap_empty_q <= (count_d == '0);
            end
        end
    end

    // A commit concurrent with reset is dropped, including its write
    assign wr_en_c = commit && push_i && !reset;

    ras_bram #(
        .DEPTH           (DEPTH),
        .WIDTH           (WIDTH),
        .RESOLVE_COLLIDE (1'b1)
    ) u_bram (
        .clk      (clk),
        .rst_i    (reset),
        .a_en_i   (rd_en_c),
        .a_addr_i (snap_tos_q[ADDR-1:0]),
        .a_data_o (restore_data),
        .b_we_i   (wr_en_c),
        .b_addr_i (addr_i[ADDR-1:0]),
        .b_data_i (data_i)
    );

    assign tos_o         = tos_q;
    assign count_o       = count_q;
    assign overflow      = ovf_q;
    assign underflow     = unf_q;
    assign mismatch      = mis_q;
    assign restore_valid = valid_q;
    assign restore_addr  = snap_tos_q;
    assign restore_empty = snap_empty_q;

endmodule

// File: tb/tb_ras_commit_stack.sv
// Directed bench for ras_commit_stack with hand-computed expectations.
module tb_ras_commit_stack;

    logic        clk;
    logic        reset;
    logic        commit;
    logic        pop_i;
    logic        push_i;
    logic [9:0]  addr_i;
    logic [31:0] data_i;
    logic [9:0]  tos_o;
    logic [4:0]  count_o;
    logic        overflow;
    logic        underflow;
    logic        mismatch;
    logic        restore_req;
    logic        restore_valid;
    logic [9:0]  restore_addr;
    logic [31:0] restore_data;
    logic        restore_empty;
    logic        restore_ack;

    int passed = 0;
    int total  = 0;

    ras_commit_stack dut (
        .clk           (clk),
        .reset         (reset),
        .commit        (commit),
        .pop_i         (pop_i),
        .push_i        (push_i),
        .addr_i        (addr_i),
        .data_i        (data_i),
        .tos_o         (tos_o),
        .count_o       (count_o),
        .overflow      (overflow),
        .underflow     (underflow),
        .mismatch      (mismatch),
        .restore_req   (restore_req),
        .restore_valid (restore_valid),
        .restore_addr  (restore_addr),
        .restore_data  (restore_data),
        .restore_empty (restore_empty),
        .restore_ack   (restore_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One committed action, then the stream goes idle
    task automatic act(input logic p, input logic q, input logic [9:0] a, input logic [31:0] d);
        commit = 1'b1;
        pop_i  = p;
        push_i = q;
        addr_i = a;
        data_i = d;
        cyc();
        commit = 1'b0;
        pop_i  = 1'b0;
        push_i = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic pulses(input string tag, input logic o, input logic u, input logic m);
        chk({tag, "_ovf"}, overflow, o);
        chk({tag, "_unf"}, underflow, u);
        chk({tag, "_mis"}, mismatch, m);
    endtask

    initial begin
        reset       = 1'b1;
        commit      = 1'b0;
        pop_i       = 1'b0;
        push_i      = 1'b0;
        addr_i      = '0;
        data_i      = '0;
        restore_req = 1'b0;
        restore_ack = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;

        // Reset state
        chk("rst_tos", tos_o, 10'h3FF);
        chk("rst_cnt", count_o, 0);
        pulses("rst", 0, 0, 0);
        chk("rst_valid", restore_valid, 0);
        chk("rst_raddr", restore_addr, 0);
        chk("rst_rdata", restore_data, 0);
        chk("rst_rempty", restore_empty, 0);

        // Two pushes then a pop
        act(0, 1, 10'd0, 32'h1000);
        chk("p0_tos", tos_o, 0);
        chk("p0_cnt", count_o, 1);
        act(0, 1, 10'd1, 32'h2000);
        chk("p1_tos", tos_o, 1);
        chk("p1_cnt", count_o, 2);
        pulses("p1", 0, 0, 0);
        act(1, 0, 10'd1, 32'h0);
        chk("pop_tos", tos_o, 0);
        chk("pop_cnt", count_o, 1);
        pulses("pop", 0, 0, 0);

        // Restore with delayed ack
        restore_req = 1'b1;
        cyc();
        restore_req = 1'b0;
        chk("r1_valid_t1", restore_valid, 0);
        cyc();
        chk("r1_valid", restore_valid, 1);
        chk("r1_addr", restore_addr, 0);
        chk("r1_data", restore_data, 32'h1000);
        chk("r1_empty", restore_empty, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("r1_hold_valid", restore_valid, 1);
            chk("r1_hold_data", restore_data, 32'h1000);
            chk("r1_hold_addr", restore_addr, 0);
        end
        restore_ack = 1'b1;
        cyc();
        restore_ack = 1'b0;
        chk("r1_ack_valid", restore_valid, 0);

        // Restore of an empty stack
        do_reset();
        restore_req = 1'b1;
        cyc();
        restore_req = 1'b0;
        cyc();
        chk("re_valid", restore_valid, 1);
        chk("re_addr", restore_addr, 10'h3FF);
        chk("re_empty", restore_empty, 1);
        restore_ack = 1'b1;
        cyc();
        restore_ack = 1'b0;

        // Seventeen pushes: wrap overwrites slot 0
        for (int i = 0; i < 16; i++) begin
            act(0, 1, 10'(i), 32'h100 + 32'(i));
            chk("fill_ovf", overflow, 0);
            chk("fill_mis", mismatch, 0);
        end
        chk("fill_cnt", count_o, 16);
        act(0, 1, 10'd16, 32'h110);
        chk("ovf_tos", tos_o, 10'h010);
        chk("ovf_cnt", count_o, 16);
        pulses("ovf", 1, 0, 0);
        cyc();
        chk("ovf_pulse_end", overflow, 0);
        restore_req = 1'b1;
        cyc();
        restore_req = 1'b0;
        cyc();
        chk("r2_addr", restore_addr, 10'h010);
        chk("r2_data", restore_data, 32'h110);
        chk("r2_empty", restore_empty, 0);
        restore_ack = 1'b1;
        cyc();
        restore_ack = 1'b0;

        // Underflow, then mismatch
        do_reset();
        act(1, 0, 10'd0, 32'h0);
        chk("unf_tos", tos_o, 10'h3FF);
        chk("unf_cnt", count_o, 0);
        pulses("unf", 0, 1, 0);
        act(0, 1, 10'd0, 32'hA);
        chk("m0_tos", tos_o, 0);
        pulses("m0", 0, 0, 0);
        act(0, 1, 10'd5, 32'hB);
        chk("mis_tos", tos_o, 5);
        chk("mis_cnt", count_o, 2);
        pulses("mis", 0, 0, 1);

        // Restore concurrent with push, replace in READ cycle forwarded
        do_reset();
        act(0, 1, 10'd0, 32'h1);
        act(0, 1, 10'd1, 32'h2);
        commit      = 1'b1;
        push_i      = 1'b1;
        addr_i      = 10'd2;
        data_i      = 32'hABCD;
        restore_req = 1'b1;
        cyc();
        restore_req = 1'b0;
        chk("c_tos", tos_o, 2);
        chk("c_cnt", count_o, 3);
        pop_i  = 1'b1;
        data_i = 32'h55;
        cyc();
        commit = 1'b0;
        pop_i  = 1'b0;
        push_i = 1'b0;
        chk("c_valid", restore_valid, 1);
        chk("c_addr", restore_addr, 2);
        chk("c_data", restore_data, 32'h55);
        chk("c_mis", mismatch, 0);
        chk("c_cnt2", count_o, 3);
        act(1, 1, 10'd2, 32'h99);
        chk("c_held_data", restore_data, 32'h55);
        chk("c_held_valid", restore_valid, 1);
        restore_ack = 1'b1;
        cyc();
        restore_ack = 1'b0;
        chk("c_ack_valid", restore_valid, 0);

        // Reset while in RESP with a concurrent commit
        restore_req = 1'b1;
        cyc();
        restore_req = 1'b0;
        cyc();
        chk("rr_valid_pre", restore_valid, 1);
        reset  = 1'b1;
        commit = 1'b1;
        push_i = 1'b1;
        addr_i = 10'd7;
        data_i = 32'hDEAD;
        cyc();
        reset  = 1'b0;
        commit = 1'b0;
        push_i = 1'b0;
        chk("rr_valid", restore_valid, 0);
        chk("rr_cnt", count_o, 0);
        chk("rr_tos", tos_o, 10'h3FF);
        pulses("rr", 0, 0, 0);
        chk("rr_data", restore_data, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
